crosswalk_request: RTL
======================

# crosswalk_request

Pedestrian push-button front end for the two-way intersection controller. It:
- synchronises and debounces the two raw crosswalk buttons;
- turns each debounced press into a sticky request;
- holds each request on `crosswalk_0`/`crosswalk_1` until the controller acknowledges service, then enforces a hold-off window.

It sits directly upstream of the light controller and drives that controller's `crosswalk_0`/`crosswalk_1` inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before the debounced level changes. Must be >= 1.
- `HOLDOFF_CYCLES`, default 32: cycles after a clear during which new presses are ignored. Must be >= 0.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-high reset. Asserted = 1.
- `btn_0` in 1: raw, asynchronous button, north crossing.
- `btn_1` in 1: raw, asynchronous button, west crossing.
- `clear_0` in 1: one-cycle acknowledge from the controller; north walk interval has started.
- `clear_1` in 1: one-cycle acknowledge from the controller; west walk interval has started.
- `crosswalk_0` out 1: pending north request, level. Feeds the controller's `crosswalk_0`.
- `crosswalk_1` out 1: pending west request, level. Feeds the controller's `crosswalk_1`.
- `holdoff_0` out 1: channel 0 is in its hold-off window.
- `holdoff_1` out 1: channel 1 is in its hold-off window.

## Operation
The two channels are identical and fully independent; x is 0 or 1.
- **Synchroniser:** `btn_x` passes through two flops, giving `sync_x`.
- **Debouncer:**
  - `deb_x` holds the debounced level; `dcnt_x` counts mismatch cycles.
  - If `sync_x` == `deb_x`, `dcnt_x` is set to 0.
  - Otherwise `dcnt_x` increments.
  - When the increment would reach `DEBOUNCE_CYCLES`, `deb_x` toggles and `dcnt_x` is set to 0.
- **Edge detect:** `press_x` = `deb_x` & ~`deb_x_prev`, a one-cycle pulse. A held button produces exactly one press.
- **Request FSM, per channel (IDLE, PENDING, HOLDOFF):**
  - IDLE: `press_x` -> PENDING. `clear_x` is ignored in IDLE.
  - PENDING: `clear_x` -> HOLDOFF, loading `hcnt_x` = `HOLDOFF_CYCLES`. Further presses are absorbed, with no counting or queuing.
  - HOLDOFF: decrement `hcnt_x` each cycle; move to IDLE on the cycle `hcnt_x` would go from 1 to 0. If `HOLDOFF_CYCLES` = 0, HOLDOFF lasts exactly one cycle. Presses are discarded; `clear_x` is ignored.
- **Outputs:** `crosswalk_x` = (state == PENDING); `holdoff_x` = (state == HOLDOFF). Both are registered state decodes with no combinational path from inputs.
- **Counter widths:** `$clog2` of (max(`DEBOUNCE_CYCLES`, `HOLDOFF_CYCLES`) + 1). Counters never wrap.
- **Simultaneous events:**
  - `press_x` and `clear_x` together in IDLE -> PENDING (the press wins; the clear is meaningless).
  - `press_x` and `clear_x` together in PENDING -> HOLDOFF (the press is dropped).
  - Channel-0 and channel-1 events in the same cycle are handled independently.

## Timing
- **Reset:** `reset_n` = 1 sampled at a rising edge forces the following on the next cycle:
  - both FSMs to IDLE;
  - all synchroniser flops, `deb_x`, and `deb_x_prev` to 0;
  - `dcnt_x` and `hcnt_x` to 0;
  - `crosswalk_0`, `crosswalk_1`, `holdoff_0`, `holdoff_1` all to 0.
- **Reset mid-operation:** a pending request is lost, and a button still held at reset release is re-debounced. It then produces one new request once stable for `DEBOUNCE_CYCLES`.
- **Press latency:** let edge k be the edge that first samples `btn_x` = 1, and `btn_x` stays high.
  - `sync_x` = 1 after edge k+1.
  - `deb_x` = 1 after edge k+1+`DEBOUNCE_CYCLES`.
  - `crosswalk_x` = 1 after edge k+2+`DEBOUNCE_CYCLES`.
- **Glitch rejection:** any high pulse on `sync_x` shorter than `DEBOUNCE_CYCLES` cycles produces no press.
- **Clear latency:**
  - `clear_x` sampled at edge c -> `crosswalk_x` = 0 and `holdoff_x` = 1 after edge c.
  - `holdoff_x` = 0 after edge c+max(`HOLDOFF_CYCLES`, 1).
- **Release:** the debounced release also needs `DEBOUNCE_CYCLES` stable-low cycles. A new press requires a full release followed by a re-press.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 and `HOLDOFF_CYCLES` = 6, with reset held for 3 edges first.
- **Basic press:** `btn_0` high from edge 10 onward -> `crosswalk_0` rises after edge 16 and stays high; `crosswalk_1` stays 0.
- **Glitch rejection:** `btn_1` high for 3 cycles, then low -> `crosswalk_1` never asserts. A 5-cycle pulse -> `crosswalk_1` asserts 6 edges after the first sampling edge.
- **Clear and hold-off:**
  - Pulse `clear_0` at edge 30 while pending -> `crosswalk_0` = 0 and `holdoff_0` = 1 after edge 30; `holdoff_0` = 0 after edge 36.
  - A re-press debounced during edges 31–36 is ignored.
  - A re-press after edge 36 asserts `crosswalk_0` again.
- **Held button and simultaneous events:**
  - Holding `btn_0` through the clear gives no second request.
  - `clear_1` in IDLE has no effect.
  - A press and `clear_0` in the same cycle while pending -> HOLDOFF.
  - Both buttons pressed on the same edge -> both `crosswalk_0` and `crosswalk_1` rise on the same edge.
- **Mid-operation reset:** assert `reset_n` for one edge while `crosswalk_0` = 1 and `btn_0` is held -> all outputs 0 the next cycle, then `crosswalk_0` returns 7 edges after reset release.

Source files
------------

// File: rtl/crosswalk_request.sv
// Crosswalk push-button front end: sync, debounce, edge detect and a
// sticky request FSM per crossing, with a hold-off window after service.

module crosswalk_channel #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int HOLDOFF_CYCLES  = 32
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn,
   input  logic clear,
   output logic crosswalk,
   output logic holdoff
);

   localparam int MAXC = (DEBOUNCE_CYCLES > HOLDOFF_CYCLES) ?
                         DEBOUNCE_CYCLES : HOLDOFF_CYCLES;
   localparam int CW = (MAXC < 1) ? 1 : $clog2(MAXC + 1);

   localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF_CYCLES);
   localparam logic [CW-1:0] ONE       = CW'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      HOLDOFF = 2'd2
   } state_t;

   logic          sync_a;
   logic          sync_b;
   logic          deb;
   logic          deb_prev;
   logic [CW-1:0] dcnt;
   logic          press;
   state_t        state;
   state_t        state_next;
   logic [CW-1:0] hcnt;
   logic [CW-1:0] hcnt_next;
   logic          crosswalk_q;
   logic          holdoff_q;

   // Two-flop synchroniser for the raw asynchronous button.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
      end else begin
         sync_a <= btn;
         sync_b <= sync_a;
      end
   end

   // Debouncer: level flips only after DEBOUNCE_CYCLES consecutive mismatches.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         deb      <= 1'b0;
         deb_prev <= 1'b0;
         dcnt     <= '0;
      end else begin
         deb_prev <= deb;
         if (sync_b == deb) begin
            dcnt <= '0;
         end else if (dcnt == DEB_LAST) begin
            deb  <= ~deb;
            dcnt <= '0;
         end else begin
            dcnt <= dcnt + ONE;
         end
      end
   end

   // One pulse per debounced rising edge; a held button never re-fires.
   assign press = deb & ~deb_prev;

   // Request state, hold-off counter and registered output decodes.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         state       <= IDLE;
         hcnt        <= '0;
         crosswalk_q <= 1'b0;
         holdoff_q   <= 1'b0;
      end else begin
         state       <= state_next;
         hcnt        <= hcnt_next;
         crosswalk_q <= (state_next == PENDING);
         holdoff_q   <= (state_next == HOLDOFF);
      end
   end

   // Next-state logic: press arms, clear starts hold-off, hold-off expires.
   always_comb begin
      state_next = state;
      hcnt_next  = hcnt;
      unique case (state)
         IDLE: begin
            if (press) begin
               state_next = PENDING;
            end
         end
         PENDING: begin
            if (clear) begin
               state_next = HOLDOFF;
               hcnt_next  = HOLD_LOAD;
            end
         end
         HOLDOFF: begin
            if (hcnt <= ONE) begin
               state_next = IDLE;
               hcnt_next  = '0;
            end else begin
               hcnt_next = hcnt - ONE;
            end
         end
         default: begin
            state_next = IDLE;
            hcnt_next  = '0;
         end
      endcase
   end

   assign crosswalk = crosswalk_q;
   assign holdoff   = holdoff_q;

endmodule

module crosswalk_request #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int HOLDOFF_CYCLES  = 32
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_0,
   input  logic btn_1,
   input  logic clear_0,
   input  logic clear_1,
   output logic crosswalk_0,
   output logic crosswalk_1,
   output logic holdoff_0,
   output logic holdoff_1
);

   // North crossing.
   crosswalk_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLDOFF_CYCLES  (HOLDOFF_CYCLES)
   ) u_ch0 (
      .clk       (clk),
      .reset_n   (reset_n),
      .btn       (btn_0),
      .clear     (clear_0),
      .crosswalk (crosswalk_0),
      .holdoff   (holdoff_0)
   );

   // West crossing.
   crosswalk_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLDOFF_CYCLES  (HOLDOFF_CYCLES)
   ) u_ch1 (
      .clk       (clk),
      .reset_n   (reset_n),
      .btn       (btn_1),
      .clear     (clear_1),
      .crosswalk (crosswalk_1),
      .holdoff   (holdoff_1)
   );

endmodule
